// File: rtl/reversi_pkg.sv
// Shared types for the cursor-move front end: direction codes, pulser FSM
// states, key priority and a counter-width helper.
package reversi_pkg;

  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_WAIT_RELEASE
  } state_e;

  // Entry 0 is the highest priority; matches the downstream updater.
  localparam logic [NUM_KEYS-1:0][1:0] PRIO_ORDER = {DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT};

  // Highest-priority pressed key (callers only use it when something is pressed).
  function automatic dir_e pick_dir(input logic [NUM_KEYS-1:0] pressed);
    dir_e d;
    d = DIR_DOWN;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (pressed[PRIO_ORDER[i]]) d = dir_e'(PRIO_ORDER[i]);
    return d;
  endfunction

  // Shared counter width: enough for the largest of the three intervals.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/move_key_pulser_if.sv
// Raw key inputs and move strobes between the board keys and the cursor updater.
interface move_key_pulser_if;
  logic keyUp;
  logic keyDown;
  logic keyLeft;
  logic keyRight;
  logic moveRightEn;
  logic moveLeftEn;
  logic moveUpEn;
  logic moveDownEn;
  logic keyHeld;

  modport master (
    output keyUp, keyDown, keyLeft, keyRight,
    input  moveRightEn, moveLeftEn, moveUpEn, moveDownEn, keyHeld
  );

  modport slave (
    input  keyUp, keyDown, keyLeft, keyRight,
    output moveRightEn, moveLeftEn, moveUpEn, moveDownEn, keyHeld
  );
endinterface

// File: rtl/key_debouncer.sv
// One key: 2-flop synchroniser followed by a stable-interval debouncer.
// Input is already polarity-normalised (1 = pressed).
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_key_pulser.sv
// Turns four raw buttons into one-hot single-cycle move strobes with
// per-key debounce, one pulse per press and auto-repeat while held.
module move_key_pulser
  import reversi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input logic              clk,
  input logic              resetn,
  move_key_pulser_if.slave bus
);

  localparam int   CW  = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic POL = (KEY_ACTIVE_LOW != 0);

  logic [NUM_KEYS-1:0] raw;   // pressed = 1, indexed by dir_e
  logic [NUM_KEYS-1:0] lvl;   // debounced levels, indexed by dir_e
  logic [NUM_KEYS-1:0] en;
  logic                held;
  state_e              state;
  dir_e                dir;
  logic [CW-1:0]       cnt;

  assign raw[DIR_RIGHT] = bus.keyRight ^ POL;
  assign raw[DIR_LEFT]  = bus.keyLeft  ^ POL;
  assign raw[DIR_UP]    = bus.keyUp    ^ POL;
  assign raw[DIR_DOWN]  = bus.keyDown  ^ POL;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CW)
    ) u_db (
      .clk   (clk),
      .resetn(resetn),
      .raw   (raw[k]),
      .level (lvl[k])
    );
  end

  // Latch one key per press, pulse on latch and on each repeat interval;
  // a release always wins over a repeat pulse due in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      dir   <= DIR_RIGHT;
      cnt   <= '0;
      en    <= '0;
      held  <= 1'b0;
    end else begin
      en <= '0;
      case (state)
        ST_IDLE: begin
          if (lvl != '0) begin
            dir                <= pick_dir(lvl);
            en[pick_dir(lvl)]  <= 1'b1;
            cnt                <= '0;
            held               <= 1'b1;
            state              <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!lvl[dir]) begin
            held  <= 1'b0;
            state <= ST_WAIT_RELEASE;
          end else if (cnt == CW'(REPEAT_DELAY - 1)) begin
            en[dir] <= 1'b1;
            cnt     <= '0;
            state   <= ST_REPEAT;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!lvl[dir]) begin
            held  <= 1'b0;
            state <= ST_WAIT_RELEASE;
          end else if (cnt == CW'(REPEAT_PERIOD - 1)) begin
            en[dir] <= 1'b1;
            cnt     <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_RELEASE: begin
          if (lvl == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.moveRightEn = en[DIR_RIGHT];
  assign bus.moveLeftEn  = en[DIR_LEFT];
  assign bus.moveUpEn    = en[DIR_UP];
  assign bus.moveDownEn  = en[DIR_DOWN];
  assign bus.keyHeld     = held;

endmodule
